// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL at 0x0, PRESET at 0x4, COUNT at 0x8 (read-only); 0xC reads as zero.
module timer_dev (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdat,
   input  logic [3:0]  byteen,
   output logic [31:0] rdat,
   output logic        irq
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CNT,
      INT
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic [31:0] count_nxt;
   logic        irq_flag;

   logic        wr;
   logic        wr_ctrl;
   logic        wr_preset;
   logic        auto_reload;
   logic        hw_clr_en;
   logic        set_flag;
   logic        drop_flag;
   logic        unused_addr_bits;

   assign wr          = |byteen;
   assign wr_ctrl     = wr && (addr[3:2] == 2'b00);
   assign wr_preset   = wr && (addr[3:2] == 2'b01);
   assign auto_reload = (ctrl_mode == 2'b01);

   assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= 32'd0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      hw_clr_en = 1'b0;
      set_flag  = 1'b0;
      drop_flag = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_en) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            count_nxt = preset;
            state_nxt = CNT;
         end
         CNT: begin
            if (!ctrl_en) begin
               state_nxt = IDLE;
            end else if (count > 32'd1) begin
               count_nxt = count - 32'd1;
            end else begin
               // Saturate at zero so a PRESET of 0 never wraps around.
               count_nxt = 32'd0;
               state_nxt = INT;
               set_flag  = 1'b1;
            end
         end
         INT: begin
            if (auto_reload) begin
               state_nxt = LOAD;
               drop_flag = 1'b1;
            end else begin
               state_nxt = IDLE;
               hw_clr_en = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // A bus write to CTRL overrides the hardware EN clear in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 2'b00;
         ctrl_im   <= 1'b0;
      end else if (wr_ctrl) begin
         if (byteen[0]) begin
            ctrl_en   <= wdat[0];
            ctrl_mode <= wdat[2:1];
            ctrl_im   <= wdat[3];
         end
      end else if (hw_clr_en) begin
         ctrl_en <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         preset <= 32'd0;
      end else if (wr_preset) begin
         for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
               preset[8*i +: 8] <= wdat[8*i +: 8];
            end
         end
      end
   end

   // A new terminal count wins over a simultaneous CTRL write so no event is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_flag <= 1'b0;
      end else if (set_flag) begin
         irq_flag <= 1'b1;
      end else if (wr_ctrl || drop_flag) begin
         irq_flag <= 1'b0;
      end
   end

   assign irq = ctrl_im & irq_flag;

   always_comb begin
      rdat = 32'd0;
      case (addr[3:2])
         2'b00:   rdat = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
         2'b01:   rdat = preset;
         2'b10:   rdat = count;
         default: rdat = 32'd0;
      endcase
   end

endmodule
